// File: rtl/mmu_pkg.sv
// ---------------------------------------------------------------------------
// mmu_pkg
// Shared types and constants for the VA->PA translator.
//  - vaddr_t / paddr_t : 32-bit addresses
//  - state_t           : translator FSM states
//  - tlb_entry_t       : one TLB entry. VPN/PFN are kept zero-extended to
//                        32 bits so the struct does not depend on PAGE_BITS.
//  - KSEG constants and the fixed-segment helper function
// Optional feature macro: TLB_ASID_EN adds ASID and global-bit fields.
// ---------------------------------------------------------------------------
package mmu_pkg;

  typedef logic [31:0] vaddr_t;
  typedef logic [31:0] paddr_t;

  // VA[31:30] == 2'b10 selects kseg0/kseg1 (fixed mapping)
  localparam logic [1:0] KSEG01_TOP = 2'b10;
  // VA[31:29] == 3'b101 selects kseg1 (uncached)
  localparam logic [2:0] KSEG1_TOP  = 3'b101;
  // Fixed mapping keeps VA[28:0] and clears the top three bits
  localparam paddr_t     KSEG_MASK  = 32'h1FFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] vpn;
    logic [31:0] pfn;
    logic        uncached;
`ifdef TLB_ASID_EN
    logic [31:0] asid;
    logic        global_pg;
`endif
  } tlb_entry_t;

  function automatic paddr_t fixed_paddr(input vaddr_t va);
    return va & KSEG_MASK;
  endfunction

endpackage

// File: rtl/tlb_cam.sv
// ---------------------------------------------------------------------------
// tlb_cam
// Fully associative TLB storage: entry array, valid bits and a parallel
// match. Lookup is combinational; install and flush act at the clock edge.
// Ports:
//  clk, reset      clock, asynchronous active-high reset (clears valid bits)
//  flush           clear every valid bit; wins over a same-cycle install
//  lookup_vpn      zero-extended VPN to match
//  lookup_asid     current ASID (TLB_ASID_EN only)
//  install_en/idx  write install_entry into slot idx and mark it valid
//  hit, hit_pfn, hit_uncached   match result (lowest matching index wins)
// Optional feature macro: TLB_ASID_EN.
// ---------------------------------------------------------------------------
module tlb_cam
  import mmu_pkg::*;
#(
  parameter int ENTRIES = 8,
  parameter int ASID_W  = 8,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [31:0]      lookup_vpn,
`ifdef TLB_ASID_EN
  input  logic [ASID_W-1:0] lookup_asid,
`endif
  input  logic             install_en,
  input  logic [IDX_W-1:0] install_idx,
  input  tlb_entry_t       install_entry,
  output logic             hit,
  output logic [31:0]      hit_pfn,
  output logic             hit_uncached
);

  tlb_entry_t         entry_mem [ENTRIES];
  logic [ENTRIES-1:0] valid_reg;
  logic [ENTRIES-1:0] match;
  logic [IDX_W-1:0]   hit_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg <= '0;
    end else if (flush) begin
      valid_reg <= '0;
    end else if (install_en) begin
      valid_reg[install_idx] <= 1'b1;
    end
  end

  // Entry payload needs no reset: it is qualified by valid_reg
  always_ff @(posedge clk) begin
    if (install_en && !flush) begin
      entry_mem[install_idx] <= install_entry;
    end
  end

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_match
`ifdef TLB_ASID_EN
    assign match[gi] = valid_reg[gi] && (entry_mem[gi].vpn == lookup_vpn) &&
                       (entry_mem[gi].global_pg ||
                        (entry_mem[gi].asid == 32'(lookup_asid)));
`else
    assign match[gi] = valid_reg[gi] && (entry_mem[gi].vpn == lookup_vpn);
`endif
  end

  // Scan from the top down so the lowest matching index is the one kept
  always_comb begin
    hit_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign hit          = |match;
  assign hit_pfn      = entry_mem[hit_idx].pfn;
  assign hit_uncached = entry_mem[hit_idx].uncached;

endmodule

// File: rtl/tlb_addr_translator.sv
// ---------------------------------------------------------------------------
// tlb_addr_translator
// MIPS-style VA->PA translation with valid/ready handshakes.
// kseg0/kseg1 are fixed-mapped; all other addresses go through an
// ENTRIES-deep fully associative TLB refilled over a request/response port.
// Ports:
//  clk, reset                 clock, asynchronous active-high reset
//  req_valid/ready/vaddr      translation request
//  resp_valid/ready           result handshake (result held until accepted)
//  resp_paddr/uncached/fault  translation result (paddr 0 on fault)
//  refill_req_valid/ready     refill request, refill_vpn = missing VPN
//  refill_resp_valid          one-cycle refill reply with refill_pfn,
//                             refill_uncached, refill_fault
//  flush                      invalidate all TLB entries
//  asid, refill_global        only with TLB_ASID_EN
// Optional feature macro: TLB_ASID_EN (ASID-tagged entries with global bit).
// ---------------------------------------------------------------------------
module tlb_addr_translator
  import mmu_pkg::*;
#(
  parameter int ENTRIES   = 8,
  parameter int PAGE_BITS = 12,
  parameter int ASID_W    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [31:0]            req_vaddr,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [31:0]            resp_paddr,
  output logic                   resp_uncached,
  output logic                   resp_fault,
  output logic                   refill_req_valid,
  input  logic                   refill_req_ready,
  output logic [31-PAGE_BITS:0]  refill_vpn,
  input  logic                   refill_resp_valid,
  input  logic [31-PAGE_BITS:0]  refill_pfn,
  input  logic                   refill_uncached,
  input  logic                   refill_fault,
`ifdef TLB_ASID_EN
  input  logic [ASID_W-1:0]      asid,
  input  logic                   refill_global,
`endif
  input  logic                   flush
);

  localparam int VPN_W = 32 - PAGE_BITS;
  localparam int IDX_W = $clog2(ENTRIES);

  if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0 || ASID_W < 1 ||
      PAGE_BITS < 1 || PAGE_BITS > 31) begin : g_param_check
    $error("tlb_addr_translator: illegal parameter combination");
  end

  state_t               state_reg, state_next;
  logic [VPN_W-1:0]     vpn_reg;
  logic [PAGE_BITS-1:0] off_reg;
  logic [IDX_W-1:0]     victim_reg;
  paddr_t               paddr_reg;
  logic                 uncached_reg;
  logic                 fault_reg;
`ifdef TLB_ASID_EN
  logic [ASID_W-1:0]    asid_reg;
`endif

  logic                 fixed_seg;
  logic                 accept;
  logic                 install_en;
  logic                 hit;
  logic [31:0]          hit_pfn;
  logic                 hit_uncached;
  tlb_entry_t           install_entry;

  assign fixed_seg = (req_vaddr[31:30] == KSEG01_TOP);
  assign accept    = req_valid && (state_reg == S_IDLE);
  // A refill reply landing together with flush is not installed, and the
  // victim pointer only moves when an entry is actually written.
  assign install_en = (state_reg == S_WAIT) && refill_resp_valid &&
                      !refill_fault && !flush;

  always_comb begin
    install_entry          = '0;
    install_entry.vpn      = 32'(vpn_reg);
    install_entry.pfn      = 32'(refill_pfn);
    install_entry.uncached = refill_uncached;
`ifdef TLB_ASID_EN
    install_entry.asid      = 32'(asid_reg);
    install_entry.global_pg = refill_global;
`endif
  end

  tlb_cam #(
    .ENTRIES (ENTRIES),
    .ASID_W  (ASID_W),
    .IDX_W   (IDX_W)
  ) u_cam (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .lookup_vpn    (32'(req_vaddr[31:PAGE_BITS])),
`ifdef TLB_ASID_EN
    .lookup_asid   (asid),
`endif
    .install_en    (install_en),
    .install_idx   (victim_reg),
    .install_entry (install_entry),
    .hit           (hit),
    .hit_pfn       (hit_pfn),
    .hit_uncached  (hit_uncached)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    req_ready        = 1'b0;
    refill_req_valid = 1'b0;
    resp_valid       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_next = (fixed_seg || hit) ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        refill_req_valid = 1'b1;
        if (refill_req_ready) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (refill_resp_valid) begin
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Result registers only change on accept or refill reply, so they are
  // naturally stable for the whole RESP state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vpn_reg      <= '0;
      off_reg      <= '0;
      victim_reg   <= '0;
      paddr_reg    <= '0;
      uncached_reg <= 1'b0;
      fault_reg    <= 1'b0;
`ifdef TLB_ASID_EN
      asid_reg     <= '0;
`endif
    end else begin
      if (accept) begin
        if (fixed_seg) begin
          paddr_reg    <= fixed_paddr(req_vaddr);
          uncached_reg <= (req_vaddr[31:29] == KSEG1_TOP);
          fault_reg    <= 1'b0;
        end else if (hit) begin
          paddr_reg    <= (hit_pfn << PAGE_BITS) | 32'(req_vaddr[PAGE_BITS-1:0]);
          uncached_reg <= hit_uncached;
          fault_reg    <= 1'b0;
        end else begin
          vpn_reg <= req_vaddr[31:PAGE_BITS];
          off_reg <= req_vaddr[PAGE_BITS-1:0];
`ifdef TLB_ASID_EN
          asid_reg <= asid;
`endif
        end
      end
      if ((state_reg == S_WAIT) && refill_resp_valid) begin
        if (refill_fault) begin
          paddr_reg    <= '0;
          uncached_reg <= 1'b0;
          fault_reg    <= 1'b1;
        end else begin
          paddr_reg    <= {refill_pfn, off_reg};
          uncached_reg <= refill_uncached;
          fault_reg    <= 1'b0;
        end
      end
      if (install_en) begin
        victim_reg <= victim_reg + 1'b1;
      end
    end
  end

  assign resp_paddr    = paddr_reg;
  assign resp_uncached = uncached_reg;
  assign resp_fault    = fault_reg;
  assign refill_vpn    = vpn_reg;

endmodule
